// File: rtl/lite_reg_responder_if.sv
// Lite register bus between a host-side master and the accelerator register block.
interface lite_reg_responder_if;
    logic        user_wren;
    logic [3:0]  user_wstrb;
    logic        user_rden;
    logic [31:0] user_addr;
    logic [31:0] user_wr_data;
    logic [31:0] user_rd_data;
    logic        user_irq;

    modport master (
        output user_wren, user_wstrb, user_rden, user_addr, user_wr_data,
        input  user_rd_data, user_irq
    );

    modport slave (
        input  user_wren, user_wstrb, user_rden, user_addr, user_wr_data,
        output user_rd_data, user_irq
    );
endinterface

// File: rtl/lite_reg_responder.sv
// Register block that launches one accelerator run per START, times it in CYCLES
// and raises a level interrupt on completion.
module lite_reg_responder #(
    parameter logic [31:0] VERSION = 32'h0001_0000
) (
    input  logic                  bus_clk,
    input  logic                  bus_rst_n,
    lite_reg_responder_if.slave   bus,
    output logic                  acc_start,
    input  logic                  acc_done
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state;
    logic        irq_en;
    logic        irq_pend;
    logic        overrun;
    logic [31:0] cycles;
    logic [31:0] scratch;
    logic [31:0] rd_mux;

    logic wr_ctrl, wr_ack, wr_scratch, start_req, soft_clr;
    logic unused_addr_bits;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign wr_ctrl    = bus.user_wren && (bus.user_addr[4:2] == 3'd0) && bus.user_wstrb[0];
    assign wr_ack     = bus.user_wren && (bus.user_addr[4:2] == 3'd2) && bus.user_wstrb[0];
    assign wr_scratch = bus.user_wren && (bus.user_addr[4:2] == 3'd4);
    assign start_req  = wr_ctrl && bus.user_wr_data[0];
    assign soft_clr   = wr_ctrl && bus.user_wr_data[2];

    assign unused_addr_bits = ^{bus.user_addr[31:5], bus.user_addr[1:0]};

    // Read mux sees pre-write state, so a same-cycle write never leaks into the read.
    always_comb begin
        rd_mux = '0;
        case (bus.user_addr[4:2])
            3'd0:    rd_mux = {30'd0, irq_en, 1'b0};
            3'd1:    rd_mux = {28'd0, overrun, irq_pend, state == DONE, state == BUSY};
            3'd3:    rd_mux = cycles;
            3'd4:    rd_mux = scratch;
            3'd5:    rd_mux = VERSION;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge bus_clk) begin
        if (!bus_rst_n) begin
            state            <= IDLE;
            irq_en           <= 1'b0;
            irq_pend         <= 1'b0;
            overrun          <= 1'b0;
            cycles           <= '0;
            scratch          <= '0;
            acc_start        <= 1'b0;
            bus.user_rd_data <= '0;
            bus.user_irq     <= 1'b0;
        end else begin
            acc_start    <= 1'b0;
            bus.user_irq <= irq_pend & irq_en;
            if (bus.user_rden)
                bus.user_rd_data <= rd_mux;
            if (wr_ctrl)
                irq_en <= bus.user_wr_data[1];
            for (int i = 0; i < 4; i++)
                if (wr_scratch && bus.user_wstrb[i])
                    scratch[8*i +: 8] <= bus.user_wr_data[8*i +: 8];

            if (soft_clr) begin
                state    <= IDLE;
                irq_pend <= 1'b0;
                overrun  <= 1'b0;
                cycles   <= '0;
            end else begin
                if (wr_ack && bus.user_wr_data[0])
                    irq_pend <= 1'b0;
                if (wr_ack && bus.user_wr_data[3])
                    overrun <= 1'b0;
                // Sets below are placed after the acks so a same-cycle event wins.
                case (state)
                    IDLE, DONE: begin
                        if (start_req) begin
                            state     <= BUSY;
                            cycles    <= '0;
                            acc_start <= 1'b1;
                        end
                    end
                    BUSY: begin
                        cycles <= sat_inc(cycles);
                        if (start_req)
                            overrun <= 1'b1;
                        if (acc_done) begin
                            state    <= DONE;
                            irq_pend <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
